risc_controller: RTL and testbench

Instruction-sequencing controller for the 8-bit RISC core. It directly drives the read and write strobes of the 32x8 synchronous data/instruction memory, and the load and increment enables of the IR, AC and PC. It steps through a fixed eight-phase cycle per instruction, decoding the 3-bit opcode from the IR. A HLT instruction parks it in a sticky halted state until reset.

---
 rtl/risc_controller.sv | 144 ++++++++++++++
 tb/tb_risc_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/risc_controller.sv
// risc_controller: instruction-sequencing controller for the 8-bit RISC core.
// Steps through an eight-phase cycle per instruction and decodes the 3-bit
// opcode into memory strobes and IR/AC/PC enables. A HLT instruction parks
// the controller in a sticky halted state that only reset clears.
//
// Ports:
//   clk      core clock, rising-edge
//   rst_     asynchronous active-low reset
//   opcode   IR[7:5], valid from OP_ADDR onward
//   zero     accumulator-equals-zero flag, sampled only in ALU_OP
//   mem_rd   memory read strobe
//   mem_wr   memory write strobe
//   load_ir  IR load enable
//   load_ac  AC load enable
//   inc_pc   PC increment enable
//   load_pc  PC load enable (jump)
//   halt     core halted indicator
//   phase    current phase (holds OP_ADDR while halted)
module risc_controller (
  input  logic       clk,
  input  logic       rst_,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       load_ir,
  output logic       load_ac,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } op_e;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  op_e    op;
  logic   aluop;

  assign op    = op_e'(opcode);
  assign aluop = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  assign phase = phase_q;

  // State register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next-state: the halted state is a separate flag; phase_q is frozen at
  // OP_ADDR so the phase output reads 4 for as long as the core is halted.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      unique case (phase_q)
        INST_ADDR:  phase_d = INST_FETCH;
        INST_FETCH: phase_d = INST_LOAD;
        INST_LOAD:  phase_d = IDLE;
        IDLE:       phase_d = OP_ADDR;
        OP_ADDR: begin
          if (op == OP_HLT) halted_d = 1'b1;
          else              phase_d  = OP_FETCH;
        end
        OP_FETCH:   phase_d = ALU_OP;
        ALU_OP:     phase_d = STORE;
        STORE:      phase_d = INST_ADDR;
        default:    phase_d = INST_ADDR;
      endcase
    end
  end

  // Output decode
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    halt    = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        INST_ADDR: ;
        INST_FETCH: mem_rd = 1'b1;
        INST_LOAD, IDLE: begin
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (op == OP_HLT);
        end
        OP_FETCH: mem_rd = aluop;
        ALU_OP: begin
          mem_rd  = aluop;
          load_ac = aluop;
          inc_pc  = (op == OP_SKZ) && zero;
          load_pc = (op == OP_JMP);
        end
        STORE: begin
          mem_rd  = aluop;
          load_ac = aluop;
          inc_pc  = (op == OP_JMP);
          load_pc = (op == OP_JMP);
          mem_wr  = (op == OP_STO);
        end
        default: ;
      endcase
    end
  end

  // The memory drops writes while read is high, so both must never coincide.
  rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst_) !(mem_rd && mem_wr));

endmodule

// File: tb/tb_risc_controller.sv
module tb_risc_controller;

  logic       clk = 1'b0;
  logic       rst_;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt;
  logic [2:0] phase;

  risc_controller dut (
    .clk     (clk),
    .rst_    (rst_),
    .opcode  (opcode),
    .zero    (zero),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .load_ir (load_ir),
    .load_ac (load_ac),
    .inc_pc  (inc_pc),
    .load_pc (load_pc),
    .halt    (halt),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  // Expected strobe bits: {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt}
  typedef struct {
    logic [2:0]      op;
    logic            z;
    logic [7:0][6:0] exp;
    string           name;
  } vec_t;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_RD   = 7'b1000000;
  localparam logic [6:0] S_RDIR = 7'b1010000;
  localparam logic [6:0] S_INC  = 7'b0000100;
  localparam logic [6:0] S_RDAC = 7'b1001000;
  localparam logic [6:0] S_WR   = 7'b0100000;
  localparam logic [6:0] S_LDPC = 7'b0000010;
  localparam logic [6:0] S_JMP7 = 7'b0000110;
  localparam logic [6:0] S_HALT = 7'b0000001;
  localparam logic [6:0] S_HLT4 = 7'b0000101;

  logic [9:0] sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  vec_t tbl[8];

  function automatic vec_t mk(input logic [2:0] op, input logic z,
                              input logic [6:0] e5, input logic [6:0] e6,
                              input logic [6:0] e7, input string name);
    vec_t v;
    v.op   = op;
    v.z    = z;
    v.name = name;
    v.exp[0] = S_NONE;
    v.exp[1] = S_RD;
    v.exp[2] = S_RDIR;
    v.exp[3] = S_RDIR;
    v.exp[4] = S_INC;
    v.exp[5] = e5;
    v.exp[6] = e6;
    v.exp[7] = e7;
    return v;
  endfunction

  task automatic chk(input string nm);
    logic [9:0] got, want;
    got  = {phase, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt};
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got=%b", nm, got);
      return;
    end
    want = sb.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got phase=%0d strobes=%b, want phase=%0d strobes=%b",
               nm, got[9:7], got[6:0], want[9:7], want[6:0]);
    end
  endtask

  // Drive inputs just after the rising edge, check at the falling edge.
  task automatic run_cycle(input logic [2:0] op, input logic z,
                           input logic [9:0] exp, input string nm);
    opcode = op;
    zero   = z;
    sb.push_back(exp);
    @(negedge clk);
    chk(nm);
    @(posedge clk);
    #1;
  endtask

  // Opcode is random before OP_ADDR and zero is random outside ALU_OP;
  // neither may influence the outputs there.
  task automatic run_instr(input vec_t v);
    for (int p = 0; p < 8; p++) begin
      logic [2:0] op;
      logic       z;
      op = (p < 4) ? 3'($urandom_range(7)) : v.op;
      z  = (p == 6) ? v.z : 1'($urandom_range(1));
      run_cycle(op, z, {3'(p), v.exp[p]}, $sformatf("%s_ph%0d", v.name, p));
    end
  endtask

  initial begin
    rst_   = 1'b0;
    opcode = 3'd0;
    zero   = 1'b0;

    tbl[0] = mk(3'd5, 1'b1, S_RD,   S_RDAC, S_RDAC, "lda");
    tbl[1] = mk(3'd2, 1'b0, S_RD,   S_RDAC, S_RDAC, "add");
    tbl[2] = mk(3'd3, 1'b1, S_RD,   S_RDAC, S_RDAC, "and");
    tbl[3] = mk(3'd4, 1'b0, S_RD,   S_RDAC, S_RDAC, "xor");
    tbl[4] = mk(3'd6, 1'b1, S_NONE, S_NONE, S_WR,   "sto");
    tbl[5] = mk(3'd1, 1'b1, S_NONE, S_INC,  S_NONE, "skz_z1");
    tbl[6] = mk(3'd1, 1'b0, S_NONE, S_NONE, S_NONE, "skz_z0");
    tbl[7] = mk(3'd7, 1'b1, S_NONE, S_LDPC, S_JMP7, "jmp");

    // Reset held for three clocks with wiggling inputs.
    #1;
    for (int i = 0; i < 3; i++)
      run_cycle(3'($urandom_range(7)), 1'($urandom_range(1)), 10'd0, "reset_hold");
    rst_ = 1'b1;

    // Table-driven instructions back to back.
    for (int i = 0; i < 8; i++) run_instr(tbl[i]);

    // Async reset in the middle of a JMP's ALU_OP phase.
    for (int p = 0; p < 6; p++)
      run_cycle((p < 4) ? 3'd2 : 3'd7, 1'b0, {3'(p), tbl[7].exp[p]}, "jmp_pre_rst");
    opcode = 3'd7;
    sb.push_back({3'd6, S_LDPC});
    #1 chk("jmp_ph6_before_rst");
    #2 rst_ = 1'b0;
    #1;
    sb.push_back(10'd0);
    chk("async_rst_mid_instr");
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    run_instr(tbl[0]);

    // HLT: halt asserts in OP_ADDR, then sticks with phase 4 and no strobes.
    for (int p = 0; p < 4; p++)
      run_cycle(3'd4, 1'b0, {3'(p), tbl[0].exp[p]}, "hlt_fetch");
    run_cycle(3'd0, 1'b1, {3'd4, S_HLT4}, "hlt_op_addr");
    for (int i = 0; i < 22; i++)
      run_cycle(3'($urandom_range(7)), 1'($urandom_range(1)), {3'd4, S_HALT},
                $sformatf("halted_%0d", i));

    // Reset pulse while halted clears everything without a clock edge.
    #2 rst_ = 1'b0;
    #1;
    sb.push_back(10'd0);
    chk("async_rst_halted");
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    run_instr(tbl[4]);
    run_instr(tbl[7]);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
